// File: rtl/mem_stage_lsu.sv
// Load/store unit for the MEM stage: word-organised data array with byte-enable
// writes, sign/zero-extended loads, and a valid/ready peripheral port for
// addresses at or above PERI_BASE.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | no peripheral access outstanding, array requests serviced
// S_PERI_WAIT | peri_valid held until peri_ready; timer hitting zero aborts
// S_PERI_RESP | peripheral access retiring, load result presented, stall low
module mem_stage_lsu #(
  parameter int          DC_ADDR_W    = 8,
  parameter logic [31:0] PERI_BASE    = 32'h0001_0000,
  parameter int          PERI_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        peri_valid,
  output logic        peri_we,
  output logic [31:0] peri_addr,
  output logic [31:0] peri_wdata,
  output logic [3:0]  peri_be,
  input  logic        peri_ready,
  input  logic [31:0] peri_rdata
);

  localparam int DEPTH = 2 ** DC_ADDR_W;
  localparam int TMR_W = $clog2(PERI_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PERI_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PERI_WAIT = 2'd1,
    S_PERI_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             align_ok;
  logic             is_peri;
  logic [3:0]       req_be;
  logic [31:0]      lane_wdata;
  logic             take, arr_st, arr_ld, peri_take, mis_take, hs;
  logic [DC_ADDR_W-1:0] arr_idx;

  logic [31:0]      mem_q [DEPTH];

  logic [31:0]      p_addr_q;
  logic             p_we_q;
  logic [3:0]       p_be_q;
  logic [31:0]      p_wdata_q;
  logic [1:0]       p_size_q;
  logic             p_uns_q;

  logic             rsp_valid_q;
  logic [31:0]      rsp_word_q;
  logic [1:0]       rsp_off_q;
  logic [1:0]       rsp_size_q;
  logic             rsp_uns_q;
  logic             mis_q;

  logic             stall_c, peri_valid_c, bus_err_c;
  logic [31:0]      rsp_shift, rsp_ext;

  // Size/alignment decode, byte enables and lane replication of store data.
  always_comb begin
    align_ok   = 1'b0;
    req_be     = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        align_ok   = 1'b1;
        req_be     = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        align_ok   = ~req_addr[0];
        req_be     = 4'b0011 << req_addr[1:0];
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        align_ok   = (req_addr[1:0] == 2'b00);
        req_be     = 4'b1111;
      end
      default: begin
        align_ok   = 1'b0;
      end
    endcase
  end

  // Only IDLE looks at the request bus; in the retire cycles the bus still
  // carries the request that is completing, so it must not be taken again.
  assign is_peri   = (req_addr >= PERI_BASE);
  assign take      = req_valid && (state_q == S_IDLE);
  assign arr_st    = take && align_ok && !is_peri && req_we;
  assign arr_ld    = take && align_ok && !is_peri && !req_we;
  assign peri_take = take && align_ok && is_peri;
  assign mis_take  = take && !align_ok;
  assign hs        = peri_valid_c && peri_ready;
  assign arr_idx   = req_addr[DC_ADDR_W+1:2];

  // Next-state, timeout timer and handshake outputs.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    stall_c      = 1'b0;
    peri_valid_c = 1'b0;
    bus_err_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = peri_take;
        if (peri_take) begin
          state_d = S_PERI_WAIT;
          tmr_d   = TMR_LOAD;
        end
      end
      S_PERI_WAIT: begin
        if (tmr_q == '0) begin
          bus_err_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          peri_valid_c = 1'b1;
          stall_c      = 1'b1;
          tmr_d        = tmr_q - 1'b1;
          if (peri_ready) begin
            state_d = S_PERI_RESP;
          end
        end
      end
      S_PERI_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured peripheral payload and registered load response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      p_addr_q    <= '0;
      p_we_q      <= 1'b0;
      p_be_q      <= '0;
      p_wdata_q   <= '0;
      p_size_q    <= '0;
      p_uns_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_word_q  <= '0;
      rsp_off_q   <= '0;
      rsp_size_q  <= '0;
      rsp_uns_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      mis_q       <= mis_take;
      rsp_valid_q <= arr_ld || (hs && !p_we_q);
      if (arr_ld) begin
        rsp_word_q <= mem_q[arr_idx];
        rsp_off_q  <= req_addr[1:0];
        rsp_size_q <= req_size;
        rsp_uns_q  <= req_unsigned;
      end else if (hs && !p_we_q) begin
        rsp_word_q <= peri_rdata;
        rsp_off_q  <= p_addr_q[1:0];
        rsp_size_q <= p_size_q;
        rsp_uns_q  <= p_uns_q;
      end
      if (peri_take) begin
        p_addr_q  <= req_addr;
        p_we_q    <= req_we;
        p_be_q    <= req_be;
        p_wdata_q <= lane_wdata;
        p_size_q  <= req_size;
        p_uns_q   <= req_unsigned;
      end
    end
  end

  // Data array: byte-masked write, contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (arr_st) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem_q[arr_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  // Lane extraction and sign/zero extension of the registered response word.
  assign rsp_shift = rsp_word_q >> {rsp_off_q, 3'b000};

  always_comb begin
    rsp_ext = rsp_shift;
    case (rsp_size_q)
      2'd0: rsp_ext = rsp_uns_q ? {24'h0, rsp_shift[7:0]}
                                : {{24{rsp_shift[7]}}, rsp_shift[7:0]};
      2'd1: rsp_ext = rsp_uns_q ? {16'h0, rsp_shift[15:0]}
                                : {{16{rsp_shift[15]}}, rsp_shift[15:0]};
      default: rsp_ext = rsp_shift;
    endcase
  end

  // Stall is gated by reset so a held request cannot freeze upstream
  // while the block is being reset.
  assign stall        = stall_c & ~rst;
  assign rdata_valid  = rsp_valid_q;
  assign rdata        = rsp_valid_q ? rsp_ext : 32'h0;
  assign misalign_err = mis_q;
  assign bus_err      = bus_err_c;
  assign peri_valid   = peri_valid_c;
  assign peri_we      = peri_valid_c & p_we_q;
  assign peri_addr    = peri_valid_c ? {p_addr_q[31:2], 2'b00} : 32'h0;
  assign peri_wdata   = peri_valid_c ? p_wdata_q : 32'h0;
  assign peri_be      = peri_valid_c ? p_be_q : 4'h0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu with a byte-level memory model and a
// behavioural peripheral responder.
module tb_mem_stage_lsu;

  localparam logic [31:0] PB = 32'h0001_0000;
  localparam int TMO = 64;

  logic        clk, rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, misalign_err, bus_err;
  logic [31:0] rdata;
  logic        peri_valid, peri_we, peri_ready;
  logic [31:0] peri_addr, peri_wdata, peri_rdata;
  logic [3:0]  peri_be;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ref_mem [1024];
  logic        exp_rv, exp_mis;
  logic [31:0] exp_rd;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata_valid(rdata_valid), .rdata(rdata),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .peri_valid(peri_valid), .peri_we(peri_we), .peri_addr(peri_addr),
    .peri_wdata(peri_wdata), .peri_be(peri_be),
    .peri_ready(peri_ready), .peri_rdata(peri_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit ref_legal(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = 1 << size;
    return (size != 2'd3) && ((addr % n) == 0);
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] raw, input int n, input logic uns);
    logic [31:0] mask, val;
    if (n >= 4) return raw;
    mask = (32'h1 << (8 * n)) - 32'h1;
    val  = raw & mask;
    if (!uns && raw[8*n-1]) val = val | ~mask;
    return val;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    int n;
    n = 1 << size;
    raw = 32'h0;
    for (int i = 0; i < n; i++) raw = raw | (32'(ref_mem[(addr + i) % 1024]) << (8 * i));
    return ref_ext(raw, n, uns);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    int n;
    n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[(addr + i) % 1024] = 8'((wdata >> (8 * i)) & 32'hFF);
  endtask

  // One array-path cycle: check the previous cycle's response, issue a request.
  task automatic array_op(input logic v, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    vectors++;
    if (rdata_valid !== exp_rv) begin
      miscompares++;
      $display("FAIL arr_rdata_valid t=%0t got=%b exp=%b", $time, rdata_valid, exp_rv);
    end
    if (exp_rv) begin
      vectors++;
      if (rdata !== exp_rd) begin
        miscompares++;
        $display("FAIL arr_rdata t=%0t got=%h exp=%h", $time, rdata, exp_rd);
      end
    end
    vectors++;
    if (misalign_err !== exp_mis || bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL arr_errs t=%0t got mis=%b bus=%b exp mis=%b bus=0", $time, misalign_err, bus_err, exp_mis);
    end
    req_valid = v; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL arr_stall t=%0t got=%b exp=0", $time, stall);
    end
    ok = ref_legal(size, addr);
    exp_rv  = v && ok && !we;
    exp_mis = v && !ok;
    exp_rd  = exp_rv ? ref_load(addr, size, uns) : 32'h0;
    if (v && ok && we) ref_store(addr, size, wdata);
    @(posedge clk); #1;
  endtask

  // Full peripheral access; lat = valid cycle in which ready is given, 0 = never.
  task automatic peri_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int lat, input logic [31:0] pword);
    logic [3:0]  ebe;
    logic [31:0] emask, ew, erd;
    int n, stalls;
    bit done;
    vectors++;
    if (rdata_valid !== exp_rv || (exp_rv && rdata !== exp_rd) || misalign_err !== exp_mis || bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL peri_prev_resp t=%0t got rv=%b rd=%h mis=%b bus=%b exp rv=%b rd=%h mis=%b bus=0",
               $time, rdata_valid, rdata, misalign_err, bus_err, exp_rv, exp_rd, exp_mis);
    end
    n   = 1 << size;
    ebe = 4'(((1 << n) - 1) << addr[1:0]);
    for (int b = 0; b < 4; b++) emask[8*b +: 8] = {8{ebe[b]}};
    ew  = wdata << (8 * addr[1:0]);
    erd = ref_ext(pword >> (8 * addr[1:0]), n, uns);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; peri_ready = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b1 || peri_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL peri_accept t=%0t got stall=%b pv=%b exp stall=1 pv=0", $time, stall, peri_valid);
    end
    stalls = (stall === 1'b1) ? 1 : 0;
    exp_rv = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    done = 0;
    for (int c = 1; c <= TMO + 5 && !done; c++) begin
      @(posedge clk); #1;
      peri_ready = (c == lat);
      peri_rdata = (c == lat) ? pword : $urandom;
      #1;
      if (c <= TMO) begin
        vectors++;
        if (peri_valid !== 1'b1 || peri_we !== we || peri_addr !== {addr[31:2], 2'b00} ||
            peri_be !== ebe || (peri_wdata & emask) !== (ew & emask) || bus_err !== 1'b0) begin
          miscompares++;
          $display("FAIL peri_payload c=%0d got pv=%b we=%b a=%h be=%h wd=%h be_err=%b exp pv=1 we=%b a=%h be=%h wd=%h(mask %h)",
                   c, peri_valid, peri_we, peri_addr, peri_be, peri_wdata, bus_err, we,
                   {addr[31:2], 2'b00}, ebe, ew, emask);
        end
        if (stall === 1'b1) stalls++;
        if (c == lat) done = 1;
      end else begin
        vectors++;
        if (peri_valid !== 1'b0 || bus_err !== 1'b1 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL peri_timeout t=%0t got pv=%b bus=%b stall=%b rv=%b exp pv=0 bus=1 stall=0 rv=0",
                   $time, peri_valid, bus_err, stall, rdata_valid);
        end
        done = 1;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      peri_ready = 1'b0;
      #1;
      vectors++;
      if (rdata_valid !== !we || (!we && rdata !== erd) || stall !== 1'b0 ||
          peri_valid !== 1'b0 || bus_err !== 1'b0) begin
        miscompares++;
        $display("FAIL peri_resp t=%0t got rv=%b rd=%h stall=%b pv=%b bus=%b exp rv=%b rd=%h stall=0 pv=0 bus=0",
                 $time, rdata_valid, rdata, stall, peri_valid, bus_err, !we, erd);
      end
    end
    vectors++;
    if (stalls != ((lat != 0) ? lat + 1 : TMO + 1)) begin
      miscompares++;
      $display("FAIL peri_stall_cycles got=%0d exp=%0d", stalls, (lat != 0) ? lat + 1 : TMO + 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; peri_ready = 1'b0; peri_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({stall, rdata_valid, misalign_err, bus_err, peri_valid, peri_we} !== 6'b0 ||
        rdata !== 32'h0 || peri_addr !== 32'h0 || peri_wdata !== 32'h0 || peri_be !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got st=%b rv=%b mis=%b bus=%b pv=%b pwe=%b rd=%h pa=%h pwd=%h pbe=%h exp all 0",
               stall, rdata_valid, misalign_err, bus_err, peri_valid, peri_we, rdata, peri_addr, peri_wdata, peri_be);
    end
    req_valid = 1'b1; req_size = 2'd2; req_addr = PB;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got=%b exp=0", stall);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rv = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_array_basic();
    array_op(1, 1, 2, 0, 32'h10, 32'hDEADBEEF);
    array_op(1, 0, 2, 0, 32'h10, 32'h0);
    vectors++;
    if (rdata_valid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL sw_lw got rv=%b rd=%h exp rv=1 rd=deadbeef", rdata_valid, rdata);
    end
    array_op(1, 1, 0, 0, 32'h13, 32'h80);
    array_op(1, 0, 0, 0, 32'h13, 32'h0);
    vectors++;
    if (rdata !== 32'hFFFFFF80) begin
      miscompares++;
      $display("FAIL lb_sign got=%h exp=ffffff80", rdata);
    end
    array_op(1, 0, 0, 1, 32'h13, 32'h0);
    vectors++;
    if (rdata !== 32'h00000080) begin
      miscompares++;
      $display("FAIL lbu_zero got=%h exp=00000080", rdata);
    end
    array_op(1, 0, 2, 0, 32'h10, 32'h0);
    vectors++;
    if (rdata !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL sb_merge got=%h exp=80adbeef", rdata);
    end
    array_op(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_misalign();
    array_op(1, 0, 1, 0, 32'h11, 32'h0);
    vectors++;
    if (misalign_err !== 1'b1 || rdata_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_lh got mis=%b rv=%b exp mis=1 rv=0", misalign_err, rdata_valid);
    end
    array_op(1, 0, 3, 0, 32'h10, 32'h0);
    vectors++;
    if (misalign_err !== 1'b1 || rdata_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_size3 got mis=%b rv=%b exp mis=1 rv=0", misalign_err, rdata_valid);
    end
    array_op(1, 1, 2, 0, 32'h12, 32'h11223344);
    array_op(1, 1, 3, 0, 32'h10, 32'h55667788);
    array_op(1, 1, 2, 0, PB + 32'h2, 32'h99AABBCC);
    vectors++;
    if (misalign_err !== 1'b1 || peri_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_peri got mis=%b pv=%b exp mis=1 pv=0", misalign_err, peri_valid);
    end
    array_op(1, 0, 2, 0, 32'h10, 32'h0);
    vectors++;
    if (rdata !== 32'h80ADBEEF) begin
      miscompares++;
      $display("FAIL misalign_unchanged got=%h exp=80adbeef", rdata);
    end
    array_op(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_array_random();
    logic [1:0]  sz;
    logic [31:0] a;
    int s;
    for (int w = 0; w < 16; w++) array_op(1, 1, 2, 0, 32'(w * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      s  = $urandom_range(0, 9);
      sz = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
      array_op(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), sz,
               1'($urandom_range(0, 1)), a, $urandom);
    end
    array_op(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_peri_load();
    peri_access(1'b0, 2'd2, 1'b0, PB + 32'h4, 32'h0, 3, 32'h12345678);
  endtask

  task automatic test_timeout();
    peri_access(1'b1, 2'd1, 1'b0, PB + 32'h2, 32'h0000ABCD, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 25; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63)) & ~((32'h1 << sz) - 32'h1);
      array_op(1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      sz = 2'($urandom_range(0, 2));
      a  = (PB + 32'($urandom_range(0, 4095))) & ~((32'h1 << sz) - 32'h1);
      peri_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  $urandom_range(1, 6), $urandom);
      exp_rv = 1'b0; exp_mis = 1'b0;
    end
    array_op(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = PB + 32'h8; req_wdata = 32'h0; peri_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (peri_valid !== 1'b1 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_wait got pv=%b stall=%b exp pv=1 stall=1", peri_valid, stall);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (peri_valid !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async got pv=%b stall=%b exp pv=0 stall=0", peri_valid, stall);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rv = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    @(posedge clk); #1;
    vectors++;
    if (rdata_valid !== 1'b0 || bus_err !== 1'b0 || peri_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_quiet got rv=%b bus=%b pv=%b exp 0 0 0", rdata_valid, bus_err, peri_valid);
    end
    array_op(1, 0, 2, 0, 32'h20, 32'h0);
    array_op(0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    exp_rv = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    test_reset();
    test_array_basic();
    test_misalign();
    test_array_random();
    test_peri_load();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    array_op(0, 0, 0, 0, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
